conn_table: RTL and testbench

Parametrised TCP connection table for the offload engine: stores up to DEPTH 4-tuple+MAC keys and returns an 8-bit-class connection ID for each. Supports lookup, lookup-or-insert and delete-by-ID over a valid/ready request handshake with a one-cycle response pulse. Keys live in a synchronous single-port RAM and per-entry valid bits in flops. A sequential scan FSM with early exit on hit and first-free-slot tracking does the search. Sits between the packet parser and the per-connection state RAMs.

---
 rtl/conn_table_pkg.sv | 44 ++++
 rtl/conn_table_mem.sv | 26 ++
 rtl/conn_table.sv | 203 ++++++++++++++++++++
 tb/tb_conn_table.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conn_table_pkg.sv
// Shared types for the connection table: request opcodes, response codes,
// FSM states and the 4-tuple+MAC key layout.
package conn_table_pkg;

  localparam int CT_MAC_W = 48;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_HIT       = 3'd0,
    ST_INSERTED  = 3'd1,
    ST_NOT_FOUND = 3'd2,
    ST_FULL      = 3'd3,
    ST_DELETED   = 3'd4,
    ST_BAD_ID    = 3'd5,
    ST_BAD_OP    = 3'd6
  } status_e;

  typedef enum logic [1:0] {
    FSM_IDLE  = 2'd0,
    FSM_SCAN  = 2'd1,
    FSM_WRITE = 2'd2
  } fsm_e;

  // Field order here matches the flat key concatenation used in the table.
  typedef struct packed {
    logic [CT_MAC_W-1:0] mac_src;
    logic [CT_MAC_W-1:0] mac_dst;
    logic [31:0]         ip_src;
    logic [31:0]         ip_dst;
    logic [15:0]         port_src;
    logic [15:0]         port_dst;
  } conn_key_t;

  function automatic int key_width(input int mac_w);
    return 2 * mac_w + 96;
  endfunction

endpackage

// File: rtl/conn_table_mem.sv
// Single-port synchronous key RAM with a registered read (one-cycle latency).
module conn_table_mem #(
  parameter int  DEPTH = 64,
  parameter int  WIDTH = 192,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/conn_table.sv
// TCP connection table: sequential-scan lookup / lookup-or-insert / delete-by-ID
// over a valid/ready request handshake, with a registered one-cycle response pulse.
module conn_table
  import conn_table_pkg::*;
#(
  parameter int  DEPTH = 64,
  parameter int  MAC_W = 48,
  localparam int ID_W  = $clog2(DEPTH)
) (
  input  logic             ct_clk,
  input  logic             ct_rst_n,
  input  logic             ct_req_valid,
  output logic             ct_req_ready,
  input  logic [1:0]       ct_req_op,
  input  logic [MAC_W-1:0] ct_mac_src,
  input  logic [MAC_W-1:0] ct_mac_dst,
  input  logic [31:0]      ct_ip_src,
  input  logic [31:0]      ct_ip_dst,
  input  logic [15:0]      ct_port_src,
  input  logic [15:0]      ct_port_dst,
  input  logic [7:0]       ct_id_in,
  output logic             ct_resp_valid,
  output logic [2:0]       ct_resp_status,
  output logic [ID_W-1:0]  ct_resp_id,
  output logic [ID_W:0]    ct_count
);

  localparam int             KEY_W   = key_width(MAC_W);
  localparam int             CNT_W   = ID_W + 1;
  localparam logic [8:0]     DEPTH_9 = 9'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fsm_e             r_state, w_state_next;
  logic [KEY_W-1:0] r_key;
  op_e              r_op;
  logic [DEPTH-1:0] r_valid;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_scan_cnt, w_scan_cnt_next;
  logic             r_resp_valid, w_resp_valid_next;
  status_e          r_resp_status, w_resp_status_next;
  logic [ID_W-1:0]  r_resp_id, w_resp_id_next;

  logic [KEY_W-1:0] w_req_key, w_rd_key, w_mem_wdata;
  logic [ID_W-1:0]  w_mem_addr, w_cmp_idx, w_free_idx, w_del_idx, w_valid_idx;
  logic             w_mem_we, w_capture, w_set_valid, w_clr_valid;
  logic             w_hit, w_last, w_id_ok;

  assign w_req_key = {ct_mac_src, ct_mac_dst, ct_ip_src, ct_ip_dst, ct_port_src, ct_port_dst};

  conn_table_mem #(
    .DEPTH (DEPTH),
    .WIDTH (KEY_W)
  ) u_mem (
    .clk     (ct_clk),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_addr),
    .i_wdata (w_mem_wdata),
    .o_rdata (w_rd_key)
  );

  // RAM q lags the scan counter by one: count value n holds entry n-1, and n==0 only primes the read.
  assign w_cmp_idx = r_scan_cnt[ID_W-1:0] - ID_W'(1);
  assign w_hit     = (r_scan_cnt != '0) && r_valid[w_cmp_idx] && (w_rd_key == r_key);
  assign w_last    = (r_scan_cnt == DEPTH_C);
  assign w_del_idx = ct_id_in[ID_W-1:0];
  assign w_id_ok   = ({1'b0, ct_id_in} < DEPTH_9) && r_valid[w_del_idx];

  always_comb begin
    w_free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_idx = ID_W'(i);
      end
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_scan_cnt_next    = '0;
    w_capture          = 1'b0;
    w_mem_we           = 1'b0;
    w_mem_addr         = r_scan_cnt[ID_W-1:0];
    w_mem_wdata        = r_key;
    w_set_valid        = 1'b0;
    w_clr_valid        = 1'b0;
    w_valid_idx        = '0;
    w_resp_valid_next  = 1'b0;
    w_resp_status_next = r_resp_status;
    w_resp_id_next     = r_resp_id;
    unique case (r_state)
      FSM_IDLE: begin
        if (ct_req_valid) begin
          case (op_e'(ct_req_op))
            OP_DELETE: begin
              w_resp_valid_next = 1'b1;
              if (w_id_ok) begin
                w_clr_valid        = 1'b1;
                w_valid_idx        = w_del_idx;
                w_resp_status_next = ST_DELETED;
                w_resp_id_next     = w_del_idx;
              end else begin
                w_resp_status_next = ST_BAD_ID;
                w_resp_id_next     = '0;
              end
            end
            OP_LOOKUP, OP_INSERT: begin
              if (r_count == '0) begin
                // Empty table: answer immediately, inserting straight from the request bus.
                w_resp_valid_next = 1'b1;
                w_resp_id_next    = '0;
                if (ct_req_op == OP_INSERT) begin
                  w_mem_we           = 1'b1;
                  w_mem_addr         = '0;
                  w_mem_wdata        = w_req_key;
                  w_set_valid        = 1'b1;
                  w_resp_status_next = ST_INSERTED;
                end else begin
                  w_resp_status_next = ST_NOT_FOUND;
                end
              end else begin
                w_capture    = 1'b1;
                w_state_next = FSM_SCAN;
              end
            end
            default: begin
              w_resp_valid_next  = 1'b1;
              w_resp_status_next = ST_BAD_OP;
              w_resp_id_next     = '0;
            end
          endcase
        end
      end
      FSM_SCAN: begin
        w_scan_cnt_next = r_scan_cnt + CNT_W'(1);
        if (w_hit) begin
          w_resp_valid_next  = 1'b1;
          w_resp_status_next = ST_HIT;
          w_resp_id_next     = w_cmp_idx;
          w_state_next       = FSM_IDLE;
        end else if (w_last) begin
          if (r_op == OP_INSERT && r_count != DEPTH_C) begin
            w_state_next = FSM_WRITE;
          end else begin
            w_resp_valid_next  = 1'b1;
            w_resp_status_next = (r_op == OP_INSERT) ? ST_FULL : ST_NOT_FOUND;
            w_resp_id_next     = '0;
            w_state_next       = FSM_IDLE;
          end
        end
      end
      FSM_WRITE: begin
        w_mem_we           = 1'b1;
        w_mem_addr         = w_free_idx;
        w_set_valid        = 1'b1;
        w_valid_idx        = w_free_idx;
        w_resp_valid_next  = 1'b1;
        w_resp_status_next = ST_INSERTED;
        w_resp_id_next     = w_free_idx;
        w_state_next       = FSM_IDLE;
      end
      default: w_state_next = FSM_IDLE;
    endcase
  end

  always_ff @(posedge ct_clk or negedge ct_rst_n) begin
    if (!ct_rst_n) begin
      r_state       <= FSM_IDLE;
      r_scan_cnt    <= '0;
      r_valid       <= '0;
      r_count       <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_status <= ST_HIT;
      r_resp_id     <= '0;
    end else begin
      r_state       <= w_state_next;
      r_scan_cnt    <= w_scan_cnt_next;
      r_resp_valid  <= w_resp_valid_next;
      r_resp_status <= w_resp_status_next;
      r_resp_id     <= w_resp_id_next;
      if (w_set_valid) begin
        r_valid[w_valid_idx] <= 1'b1;
        r_count              <= r_count + CNT_W'(1);
      end else if (w_clr_valid) begin
        r_valid[w_valid_idx] <= 1'b0;
        r_count              <= r_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge ct_clk) begin
    if (w_capture) begin
      r_key <= w_req_key;
      r_op  <= op_e'(ct_req_op);
    end
  end

  assign ct_req_ready   = (r_state == FSM_IDLE);
  assign ct_resp_valid  = r_resp_valid;
  assign ct_resp_status = r_resp_status;
  assign ct_resp_id     = r_resp_id;
  assign ct_count       = r_count;

endmodule

// File: tb/tb_conn_table.sv
// Directed bench for conn_table at DEPTH=8: table-driven request sequences
// with hand-computed status, id, response latency and occupancy.
module tb_conn_table;
  import conn_table_pkg::*;

  localparam int DEPTH = 8;
  localparam int MAC_W = 48;
  localparam int ID_W  = 3;
  localparam int LOOK = 0, INS = 1, DEL = 2, RSV = 3;

  typedef struct {
    int op; int kn; int id; int st; int rid; int lat; int cnt;
  } vec_t;

  logic             clk = 1'b0;
  logic             ct_rst_n;
  logic             ct_req_valid;
  logic             ct_req_ready;
  logic [1:0]       ct_req_op;
  logic [MAC_W-1:0] ct_mac_src, ct_mac_dst;
  logic [31:0]      ct_ip_src, ct_ip_dst;
  logic [15:0]      ct_port_src, ct_port_dst;
  logic [7:0]       ct_id_in;
  logic             ct_resp_valid;
  logic [2:0]       ct_resp_status;
  logic [ID_W-1:0]  ct_resp_id;
  logic [ID_W:0]    ct_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conn_table #(.DEPTH(DEPTH), .MAC_W(MAC_W)) dut (
    .ct_clk        (clk),
    .ct_rst_n      (ct_rst_n),
    .ct_req_valid  (ct_req_valid),
    .ct_req_ready  (ct_req_ready),
    .ct_req_op     (ct_req_op),
    .ct_mac_src    (ct_mac_src),
    .ct_mac_dst    (ct_mac_dst),
    .ct_ip_src     (ct_ip_src),
    .ct_ip_dst     (ct_ip_dst),
    .ct_port_src   (ct_port_src),
    .ct_port_dst   (ct_port_dst),
    .ct_id_in      (ct_id_in),
    .ct_resp_valid (ct_resp_valid),
    .ct_resp_status(ct_resp_status),
    .ct_resp_id    (ct_resp_id),
    .ct_count      (ct_count)
  );

  // Keys mk(2m) and mk(2m+1) differ only in the port_dst LSB.
  function automatic conn_key_t mk(input int n);
    conn_key_t k;
    int h;
    h = n >> 1;
    k.mac_src  = 48'h02AA_0000_0000 + 48'(h);
    k.mac_dst  = 48'h02BB_0000_1000 + 48'(h * 3);
    k.ip_src   = 32'h0A00_0001 + 32'(h);
    k.ip_dst   = 32'hC0A8_0100 + 32'(h * 5);
    k.port_src = 16'd4000 + 16'(h);
    k.port_dst = 16'(32'h800 + h * 2 + (n & 1));
    return k;
  endfunction

  task automatic set_key(input conn_key_t k);
    ct_mac_src  = k.mac_src;
    ct_mac_dst  = k.mac_dst;
    ct_ip_src   = k.ip_src;
    ct_ip_dst   = k.ip_dst;
    ct_port_src = k.port_src;
    ct_port_dst = k.port_dst;
  endtask

  // Latency counts edges after the accepting edge E0; -1 means no response arrived.
  task automatic do_req(input int op, input int kn, input int id,
                        output int lat, output logic [2:0] st, output logic [ID_W-1:0] rid);
    int n;
    @(negedge clk);
    ct_req_op    = 2'(op);
    set_key(mk(kn));
    ct_id_in     = 8'(id);
    ct_req_valid = 1'b1;
    n = 0;
    while (!ct_req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    ct_req_valid = 1'b0;
    lat = 0;
    while (!ct_resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!ct_resp_valid) lat = -1;
    st  = ct_resp_status;
    rid = ct_resp_id;
    $display("req op=%0d key=%0d id=%0d -> status=%0d id=%0d lat=%0d count=%0d",
             op, kn, id, st, rid, lat, ct_count);
  endtask

  task automatic test_reset;
    ct_rst_n     = 1'b0;
    ct_req_valid = 1'b0;
    ct_req_op    = 2'd0;
    ct_id_in     = 8'd0;
    set_key(mk(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    ct_rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (ct_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b expected 1", ct_req_ready); end
    checks++; if (ct_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %0b expected 0", ct_resp_valid); end
    checks++; if (ct_resp_status !== 3'd0) begin errors++; $display("FAIL reset_status got %0d expected 0", ct_resp_status); end
    checks++; if (ct_resp_id !== 3'd0) begin errors++; $display("FAIL reset_id got %0d expected 0", ct_resp_id); end
    checks++; if (ct_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", ct_count); end
  endtask

  task automatic test_empty;
    vec_t v [2] = '{
      '{LOOK, 2, 0, ST_NOT_FOUND, 0, 0, 0},
      '{INS,  2, 0, ST_INSERTED,  0, 0, 1}
    };
    int lat; logic [2:0] st; logic [ID_W-1:0] rid;
    foreach (v[i]) begin
      do_req(v[i].op, v[i].kn, v[i].id, lat, st, rid);
      checks++; if (st !== 3'(v[i].st)) begin errors++; $display("FAIL empty[%0d] status got %0d expected %0d", i, st, v[i].st); end
      checks++; if (rid !== ID_W'(v[i].rid)) begin errors++; $display("FAIL empty[%0d] id got %0d expected %0d", i, rid, v[i].rid); end
      checks++; if (lat != v[i].lat) begin errors++; $display("FAIL empty[%0d] latency got %0d expected %0d", i, lat, v[i].lat); end
      checks++; if (ct_count !== 4'(v[i].cnt)) begin errors++; $display("FAIL empty[%0d] count got %0d expected %0d", i, ct_count, v[i].cnt); end
    end
    @(posedge clk);
    #1;
    checks++; if (ct_resp_valid !== 1'b0) begin errors++; $display("FAIL pulse_width resp_valid got %0b expected 0", ct_resp_valid); end
    checks++; if (ct_resp_status !== 3'(ST_INSERTED)) begin errors++; $display("FAIL status_hold got %0d expected 1", ct_resp_status); end
  endtask

  task automatic test_insert_hit;
    vec_t v [5] = '{
      '{INS,  4, 0, ST_INSERTED, 1, 10, 2},
      '{INS,  6, 0, ST_INSERTED, 2, 10, 3},
      '{LOOK, 6, 0, ST_HIT,      2,  4, 3},
      '{INS,  4, 0, ST_HIT,      1,  3, 3},
      '{LOOK, 2, 0, ST_HIT,      0,  2, 3}
    };
    int lat; logic [2:0] st; logic [ID_W-1:0] rid;
    foreach (v[i]) begin
      do_req(v[i].op, v[i].kn, v[i].id, lat, st, rid);
      checks++; if (st !== 3'(v[i].st)) begin errors++; $display("FAIL insert_hit[%0d] status got %0d expected %0d", i, st, v[i].st); end
      checks++; if (rid !== ID_W'(v[i].rid)) begin errors++; $display("FAIL insert_hit[%0d] id got %0d expected %0d", i, rid, v[i].rid); end
      checks++; if (lat != v[i].lat) begin errors++; $display("FAIL insert_hit[%0d] latency got %0d expected %0d", i, lat, v[i].lat); end
      checks++; if (ct_count !== 4'(v[i].cnt)) begin errors++; $display("FAIL insert_hit[%0d] count got %0d expected %0d", i, ct_count, v[i].cnt); end
    end
  endtask

  task automatic test_delete;
    vec_t v [8] = '{
      '{DEL,  0, 1, ST_DELETED,   1,  0, 2},
      '{LOOK, 4, 0, ST_NOT_FOUND, 0,  9, 2},
      '{INS,  8, 0, ST_INSERTED,  1, 10, 3},
      '{DEL,  0, 1, ST_DELETED,   1,  0, 2},
      '{DEL,  0, 1, ST_BAD_ID,    0,  0, 2},
      '{DEL,  0, 9, ST_BAD_ID,    0,  0, 2},
      '{DEL,  0, 8, ST_BAD_ID,    0,  0, 2},
      '{RSV,  2, 0, ST_BAD_OP,    0,  0, 2}
    };
    int lat; logic [2:0] st; logic [ID_W-1:0] rid;
    foreach (v[i]) begin
      do_req(v[i].op, v[i].kn, v[i].id, lat, st, rid);
      checks++; if (st !== 3'(v[i].st)) begin errors++; $display("FAIL delete[%0d] status got %0d expected %0d", i, st, v[i].st); end
      checks++; if (rid !== ID_W'(v[i].rid)) begin errors++; $display("FAIL delete[%0d] id got %0d expected %0d", i, rid, v[i].rid); end
      checks++; if (lat != v[i].lat) begin errors++; $display("FAIL delete[%0d] latency got %0d expected %0d", i, lat, v[i].lat); end
      checks++; if (ct_count !== 4'(v[i].cnt)) begin errors++; $display("FAIL delete[%0d] count got %0d expected %0d", i, ct_count, v[i].cnt); end
    end
  endtask

  // Live entries on entry: 0=mk(2), 2=mk(6); fills the remaining holes lowest-first.
  task automatic test_full;
    vec_t v [11] = '{
      '{INS,  10, 0, ST_INSERTED,  1, 10, 3},
      '{INS,  11, 0, ST_INSERTED,  3, 10, 4},
      '{INS,  12, 0, ST_INSERTED,  4, 10, 5},
      '{INS,  13, 0, ST_INSERTED,  5, 10, 6},
      '{INS,  14, 0, ST_INSERTED,  6, 10, 7},
      '{INS,  15, 0, ST_INSERTED,  7, 10, 8},
      '{INS,   3, 0, ST_FULL,      0,  9, 8},
      '{LOOK, 11, 0, ST_HIT,       3,  5, 8},
      '{LOOK, 10, 0, ST_HIT,       1,  3, 8},
      '{LOOK,  3, 0, ST_NOT_FOUND, 0,  9, 8},
      '{LOOK,  7, 0, ST_NOT_FOUND, 0,  9, 8}
    };
    int lat; logic [2:0] st; logic [ID_W-1:0] rid;
    foreach (v[i]) begin
      do_req(v[i].op, v[i].kn, v[i].id, lat, st, rid);
      checks++; if (st !== 3'(v[i].st)) begin errors++; $display("FAIL full[%0d] status got %0d expected %0d", i, st, v[i].st); end
      checks++; if (rid !== ID_W'(v[i].rid)) begin errors++; $display("FAIL full[%0d] id got %0d expected %0d", i, rid, v[i].rid); end
      checks++; if (lat != v[i].lat) begin errors++; $display("FAIL full[%0d] latency got %0d expected %0d", i, lat, v[i].lat); end
      checks++; if (ct_count !== 4'(v[i].cnt)) begin errors++; $display("FAIL full[%0d] count got %0d expected %0d", i, ct_count, v[i].cnt); end
    end
  endtask

  // LOOKUP mk(15) (entry 7) with a second LOOKUP mk(11) (entry 3) held behind it.
  task automatic test_hold;
    int ready_bad, lat_a, lat_b;
    @(negedge clk);
    ct_req_op    = 2'(LOOK);
    set_key(mk(15));
    ct_req_valid = 1'b1;
    @(posedge clk);
    #1;
    set_key(mk(11));
    ready_bad = 0;
    lat_a = 0;
    while (!ct_resp_valid && lat_a < 40) begin
      if (ct_req_ready) ready_bad++;
      @(posedge clk);
      #1;
      lat_a++;
    end
    $display("hold first: status=%0d id=%0d lat=%0d ready=%0b", ct_resp_status, ct_resp_id, lat_a, ct_req_ready);
    checks++; if (ready_bad != 0) begin errors++; $display("FAIL hold_ready_low got %0d ready-high cycles expected 0", ready_bad); end
    checks++; if (lat_a != 9) begin errors++; $display("FAIL hold_first_latency got %0d expected 9", lat_a); end
    checks++; if (ct_resp_status !== 3'(ST_HIT)) begin errors++; $display("FAIL hold_first_status got %0d expected 0", ct_resp_status); end
    checks++; if (ct_resp_id !== 3'd7) begin errors++; $display("FAIL hold_first_id got %0d expected 7", ct_resp_id); end
    checks++; if (ct_req_ready !== 1'b1) begin errors++; $display("FAIL hold_ready_in_resp_cycle got %0b expected 1", ct_req_ready); end
    @(posedge clk);
    #1;
    ct_req_valid = 1'b0;
    lat_b = 0;
    while (!ct_resp_valid && lat_b < 40) begin
      @(posedge clk);
      #1;
      lat_b++;
    end
    $display("hold second: status=%0d id=%0d lat=%0d", ct_resp_status, ct_resp_id, lat_b);
    checks++; if (lat_b != 5) begin errors++; $display("FAIL hold_second_latency got %0d expected 5", lat_b); end
    checks++; if (ct_resp_status !== 3'(ST_HIT)) begin errors++; $display("FAIL hold_second_status got %0d expected 0", ct_resp_status); end
    checks++; if (ct_resp_id !== 3'd3) begin errors++; $display("FAIL hold_second_id got %0d expected 3", ct_resp_id); end
  endtask

  task automatic test_reset_mid_scan;
    vec_t v [4] = '{
      '{LOOK,  2, 0, ST_NOT_FOUND, 0, 0, 0},
      '{INS,   6, 0, ST_INSERTED,  0, 0, 1},
      '{LOOK, 10, 0, ST_NOT_FOUND, 0, 9, 1},
      '{LOOK,  6, 0, ST_HIT,       0, 2, 1}
    };
    int lat; logic [2:0] st; logic [ID_W-1:0] rid;
    int seen;
    @(negedge clk);
    ct_req_op    = 2'(LOOK);
    set_key(mk(15));
    ct_req_valid = 1'b1;
    @(posedge clk);
    #1;
    ct_req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    ct_rst_n = 1'b0;
    #2;
    checks++; if (ct_count !== 4'd0) begin errors++; $display("FAIL midscan_count_in_reset got %0d expected 0", ct_count); end
    checks++; if (ct_req_ready !== 1'b1) begin errors++; $display("FAIL midscan_ready_in_reset got %0b expected 1", ct_req_ready); end
    @(negedge clk);
    ct_rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (ct_resp_valid) seen++;
    end
    $display("midscan reset: resp pulses=%0d count=%0d", seen, ct_count);
    checks++; if (seen != 0) begin errors++; $display("FAIL midscan_no_resp got %0d pulses expected 0", seen); end
    foreach (v[i]) begin
      do_req(v[i].op, v[i].kn, v[i].id, lat, st, rid);
      checks++; if (st !== 3'(v[i].st)) begin errors++; $display("FAIL midscan[%0d] status got %0d expected %0d", i, st, v[i].st); end
      checks++; if (rid !== ID_W'(v[i].rid)) begin errors++; $display("FAIL midscan[%0d] id got %0d expected %0d", i, rid, v[i].rid); end
      checks++; if (lat != v[i].lat) begin errors++; $display("FAIL midscan[%0d] latency got %0d expected %0d", i, lat, v[i].lat); end
      checks++; if (ct_count !== 4'(v[i].cnt)) begin errors++; $display("FAIL midscan[%0d] count got %0d expected %0d", i, ct_count, v[i].cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_insert_hit();
    test_delete();
    test_full();
    test_hold();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
